// File: rtl/bit_entry_conditioner.sv
// Synchronizes and debounces the data switch and step button, then turns each
// debounced button press into one accepted bit (held level + one-cycle strobe).
module bit_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       sw_data,
  input  logic       btn_step,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       btn_level,
  output logic [7:0] history,
  output logic [7:0] bit_count
);

  localparam int NUM_IN   = 2;
  localparam int IDX_DATA = 0;
  localparam int IDX_BTN  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_RELEASED = 1'b0;
  localparam logic [0:0] ST_PRESSED  = 1'b1;

  logic [NUM_IN-1:0]            raw;
  logic [NUM_IN-1:0]            s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, flip;
  logic [NUM_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]                   state_q, state_d;
  logic                         bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic [7:0]                   history_q, history_d, bit_count_q, bit_count_d;
  logic                         rise, fall, accept, data_lvl;

  assign raw      = {btn_step, sw_data};
  assign data_lvl = lvl_q[IDX_DATA];

  // Per-input synchronizer and debouncer; flip marks the edge a level changes.
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    for (int i = 0; i < NUM_IN; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      flip[i]  = 1'b0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = s2_q[i];
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = flip[IDX_BTN] &  s2_q[IDX_BTN];
  assign fall = flip[IDX_BTN] & ~s2_q[IDX_BTN];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_RELEASED: if (rise) begin
        state_d = ST_PRESSED;
        accept  = ena;
      end
      ST_PRESSED: if (fall) state_d = ST_RELEASED;
      default: state_d = ST_RELEASED;
    endcase
  end

  // The accepted bit uses data_lvl as registered, before any same-edge flip.
  always_comb begin
    bit_out_d   = bit_out_q;
    bit_valid_d = accept;
    history_d   = history_q;
    bit_count_d = bit_count_q;
    if (accept) begin
      bit_out_d   = data_lvl;
      history_d   = {history_q[6:0], data_lvl};
      bit_count_d = (bit_count_q == 8'hFF) ? 8'hFF : bit_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      lvl_q       <= '0;
      cnt_q       <= '0;
      state_q     <= ST_RELEASED;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      history_q   <= 8'h00;
      bit_count_q <= 8'h00;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      lvl_q       <= lvl_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      history_q   <= history_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign btn_level = lvl_q[IDX_BTN];
  assign history   = history_q;
  assign bit_count = bit_count_q;

endmodule

// File: doc/bit_entry_conditioner.md
# bit_entry_conditioner

Front-end stage for the 01[0*]1 sequence detector. It synchronizes and debounces two raw board inputs: a data switch and a step pushbutton. Each debounced press of the step button is converted into exactly one accepted bit, presented as a held level plus a one-cycle strobe. The detector consumes `bit_out` as its test signal, clocked by `bit_valid`. The block also keeps an 8-bit history and a saturating count of accepted bits for board debug.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `ena`  in  1  accept enable; while low, presses are debounced but discarded
- `sw_data`  in  1  raw, asynchronous data switch (1 = bit value 1)
- `btn_step`  in  1  raw, asynchronous step pushbutton, active-high
- `bit_out`  out  1  most recently accepted bit, held until the next accept
- `bit_valid`  out  1  one-cycle strobe marking a new accepted bit
- `btn_level`  out  1  debounced button level
- `history`  out  8  last 8 accepted bits; bit 0 is newest
- `bit_count`  out  8  number of accepted bits, saturating at 255

## Operation
- **Synchronizers:** each raw input passes through a 2-flop synchronizer (`s1` → `s2`).
- **Debouncer (one per input):** each has a stable level `lvl` and a counter `cnt`. At every edge:
  - if `s2 == lvl`: `cnt <= 0`.
  - else if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2` and `cnt <= 0`.
  - else: `cnt <= cnt + 1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `lvl`.
- **Data:** the debounced data level is `data_lvl`. The button's debounced level drives `btn_level`.
- **Button FSM:** two states, RELEASED and PRESSED.
  - RELEASED → PRESSED on the edge where the button debouncer flips its level 0→1. This edge is an "accept" if `ena == 1` at that edge.
  - PRESSED → RELEASED on the edge where the level flips 1→0. No accept occurs on release.
  - Holding the button produces exactly one accept. There is no auto-repeat.
- **On an accept edge:**
  - `bit_out <= data_lvl`, using the value before any same-edge update of `data_lvl`.
  - `bit_valid <= 1` for one cycle.
  - `history <= {history[6:0], data_lvl}`.
  - `bit_count <= (bit_count == 255) ? 255 : bit_count + 1`.
- **On non-accept edges:** `bit_valid <= 0` and all other outputs hold.
- **`ena` low:** the FSM still advances, so a press made while `ena` is low is consumed. Raising `ena` during a held press does not generate an accept.

## Timing
- **Reset values:** `bit_out` = 0, `bit_valid` = 0, `btn_level` = 0, `history` = 8'h00, `bit_count` = 0. Synchronizer flops, both `lvl` registers and both counters are 0; the FSM is in RELEASED.
- **Latency:** take edge 0 as the first edge that samples a raw input change, with the input held. The debounced level flips at edge `DEBOUNCE_CYCLES+1`.
  - For the button, `bit_valid` is high from edge `DEBOUNCE_CYCLES+1` to edge `DEBOUNCE_CYCLES+2`. `bit_out`, `history` and `bit_count` update at edge `DEBOUNCE_CYCLES+1`.
- **Data and button changing together:** if both raw inputs change at the same edge, both debouncers flip at the same edge. The accepted bit is therefore the old data value. Data must be set up ≥ 1 cycle before the button settles.
- **Minimum spacing:** two accepts are separated by at least `2*DEBOUNCE_CYCLES+2` cycles, because a release must debounce in between.
- **Reset mid-operation:** `rst` overrides everything at that edge. All outputs return to reset values, and a pending `bit_valid` is cleared.
  - A button held through reset release is accepted as a fresh press `DEBOUNCE_CYCLES+1` edges after the first post-reset sample, provided `ena` = 1.
- **Downstream contract:** the detector may sample `bit_out` on any cycle where `bit_valid` = 1. `bit_out` is also stable for the whole following inter-accept interval.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `ena` = 1 unless noted.
1. **Reset:** apply reset, then release it with both inputs low → all outputs 0; after 20 cycles, `bit_valid` has never pulsed.
2. **Clean press:** `sw_data` = 1 held, then `btn_step` rises, first sampled at edge 0 and held for 12 cycles → `bit_valid` high only between edges 5 and 6, `bit_out` = 1, `history` = 8'h01, `bit_count` = 1. After release, no further strobe.
3. **Bounce rejection:** `btn_step` toggles with high pulses of 1–3 cycles for 30 cycles, then holds high → exactly one `bit_valid`, occurring 5 edges after the final rising sample.
4. **Sequence feed:** press the button for the bits 0,1,0,0,1 with a clean release between each → five strobes, `bit_out` values in order 0,1,0,0,1, `history` = 8'h09, `bit_count` = 5.
5. **Enable gating and saturation:**
   - Press with `ena` = 0 → `btn_level` rises, but there is no strobe and `history`/`bit_count` are unchanged.
   - Then 260 accepted presses → `bit_count` stops at 255.
6. **Simultaneous change and reset:**
   - Switch data from 0 to 1 on the same cycle as the press → `bit_out` = 0.
   - Assert `rst` on the cycle the strobe would fire → `bit_valid` stays 0 and all outputs are cleared.
